phase_controller: RTL and testbench

- Control-side partner of the CPU's four-phase sequence generator (fetch -> decode -> execute -> increment, one-hot).
- Consumes the one-hot phase strobes and produces the `clock_enable` that advances the generator.
- In each phase it performs the phase's work (memory handshake, IR load, accumulator load, PC update) and stalls the generator until that work completes.
- Flags non-one-hot phase vectors and memory timeouts.

---
 rtl/phase_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_phase_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_controller.sv
// -----------------------------------------------------------------------------
// phase_controller
//
// Control-side partner of the CPU's four-phase sequence generator
// (fetch -> decode -> execute -> increment, one-hot). For each phase it does
// that phase's work, then raises clock_enable for one cycle so the generator
// moves on. Until the work is done, the generator is held.
//
// Per-phase work:
//   fetch     : memory read at the PC address, then load the IR.
//   decode    : latch the opcode from the IR.
//   execute   : opcode-dependent. LDA/STA do a memory handshake at the operand
//               address. ADD/SUB load the accumulator. JMP loads the PC.
//               HLT halts the machine.
//   increment : PC+1, skipped once after a JMP.
//
// Ports:
//   clock         in   system clock, rising edge
//   clear         in   synchronous active-high reset (shared with generator)
//   fetch/decode/execute/increment
//                 in   one-hot phase strobes from the sequence generator
//   instruction   in   [7:0] IR contents; opcode is instruction[7:4]
//   mem_ready     in   memory completion, sampled while waiting
//   clock_enable  out  one-cycle advance pulse to the sequence generator
//   mem_read      out  memory read request
//   mem_write     out  memory write request
//   mem_addr_sel  out  0 = PC address, 1 = operand address
//   ir_load       out  one-cycle IR load strobe
//   acc_load      out  one-cycle accumulator load strobe
//   alu_sub       out  ALU subtract select, qualified by acc_load
//   pc_increment  out  one-cycle PC+1 strobe
//   pc_load       out  one-cycle PC jump-load strobe
//   halted        out  sticky, HLT executed
//   phase_error   out  sticky, phase vector not one-hot or changed mid-wait
//   bus_error     out  sticky, memory did not answer within MEM_TIMEOUT cycles
//
// Parameter:
//   MEM_TIMEOUT   maximum WAIT_MEM cycles without mem_ready (1..255)
// -----------------------------------------------------------------------------
module phase_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       fetch,
    input  logic       decode,
    input  logic       execute,
    input  logic       increment,
    input  logic [7:0] instruction,
    input  logic       mem_ready,
    output logic       clock_enable,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_addr_sel,
    output logic       ir_load,
    output logic       acc_load,
    output logic       alu_sub,
    output logic       pc_increment,
    output logic       pc_load,
    output logic       halted,
    output logic       phase_error,
    output logic       bus_error
);

    typedef enum logic [2:0] {
        DISPATCH,
        WAIT_MEM,
        ADVANCE,
        HALT,
        ERROR
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     state;
    logic [3:0] phase_cap;   // phase vector seen when the wait started
    logic [7:0] wait_cnt;    // cycles spent in WAIT_MEM without mem_ready
    logic [3:0] opcode;      // latched in the decode phase
    logic       jump_flag;   // set by JMP; suppresses the next PC+1

    // Bit order: [0] fetch, [1] decode, [2] execute, [3] increment.
    logic [3:0] phase_vec;
    assign phase_vec = {increment, execute, decode, fetch};

    // The operand nibble belongs to the datapath, not to sequencing.
    logic unused_operand;
    assign unused_operand = ^instruction[3:0];

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state        <= DISPATCH;
            phase_cap    <= 4'b0000;
            wait_cnt     <= 8'd0;
            opcode       <= 4'h0;
            jump_flag    <= 1'b0;
            clock_enable <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr_sel <= 1'b0;
            ir_load      <= 1'b0;
            acc_load     <= 1'b0;
            alu_sub      <= 1'b0;
            pc_increment <= 1'b0;
            pc_load      <= 1'b0;
            halted       <= 1'b0;
            phase_error  <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            // Single-cycle strobes default low. They are raised only when
            // moving into ADVANCE, so each one lasts exactly one cycle.
            clock_enable <= 1'b0;
            ir_load      <= 1'b0;
            acc_load     <= 1'b0;
            alu_sub      <= 1'b0;
            pc_increment <= 1'b0;
            pc_load      <= 1'b0;

            case (state)
                DISPATCH: begin
                    phase_cap <= phase_vec;
                    wait_cnt  <= 8'd0;
                    if (!is_onehot(phase_vec)) begin
                        state       <= ERROR;
                        phase_error <= 1'b1;
                    end else if (fetch) begin
                        state        <= WAIT_MEM;
                        mem_read     <= 1'b1;
                        mem_addr_sel <= 1'b0;
                    end else if (decode) begin
                        opcode       <= instruction[7:4];
                        state        <= ADVANCE;
                        clock_enable <= 1'b1;
                    end else if (execute) begin
                        case (opcode)
                            OP_LDA: begin
                                state        <= WAIT_MEM;
                                mem_read     <= 1'b1;
                                mem_addr_sel <= 1'b1;
                            end
                            OP_STA: begin
                                state        <= WAIT_MEM;
                                mem_write    <= 1'b1;
                                mem_addr_sel <= 1'b1;
                            end
                            OP_ADD: begin
                                state        <= ADVANCE;
                                clock_enable <= 1'b1;
                                acc_load     <= 1'b1;
                            end
                            OP_SUB: begin
                                state        <= ADVANCE;
                                clock_enable <= 1'b1;
                                acc_load     <= 1'b1;
                                alu_sub      <= 1'b1;
                            end
                            OP_JMP: begin
                                state        <= ADVANCE;
                                clock_enable <= 1'b1;
                                pc_load      <= 1'b1;
                                jump_flag    <= 1'b1;
                            end
                            OP_HLT: begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end
                            default: begin
                                state        <= ADVANCE;
                                clock_enable <= 1'b1;
                            end
                        endcase
                    end else begin
                        // Increment phase. The PC already holds the jump
                        // target, so the +1 is skipped once after a JMP.
                        state        <= ADVANCE;
                        clock_enable <= 1'b1;
                        if (jump_flag) begin
                            jump_flag <= 1'b0;
                        end else begin
                            pc_increment <= 1'b1;
                        end
                    end
                end

                WAIT_MEM: begin
                    // The generator is stalled, so any phase change means
                    // the generator is corrupted. This check takes priority
                    // because a stale request must not be completed.
                    if (phase_vec != phase_cap) begin
                        state        <= ERROR;
                        phase_error  <= 1'b1;
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        mem_addr_sel <= 1'b0;
                    end else if (mem_ready) begin
                        // A ready in the final allowed cycle still completes.
                        state        <= ADVANCE;
                        clock_enable <= 1'b1;
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        mem_addr_sel <= 1'b0;
                        if (phase_cap[0]) begin
                            ir_load <= 1'b1;
                        end else if (opcode == OP_LDA) begin
                            acc_load <= 1'b1;
                        end
                    end else if ((wait_cnt + 8'd1) == TIMEOUT_LIMIT) begin
                        state        <= ERROR;
                        bus_error    <= 1'b1;
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        mem_addr_sel <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ADVANCE: begin
                    // The generator steps at this edge, so DISPATCH samples
                    // the new phase on the next cycle.
                    state <= DISPATCH;
                end

                HALT, ERROR: begin
                    // Terminal states: only clear leaves them. Sticky flags
                    // keep their values.
                    mem_read     <= 1'b0;
                    mem_write    <= 1'b0;
                    mem_addr_sel <= 1'b0;
                end

                default: begin
                    state       <= ERROR;
                    phase_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_controller.sv
module tb_phase_controller;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [7:0] instruction = 8'h00;
    logic       mem_ready = 1'b0;

    logic clock_enable, mem_read, mem_write, mem_addr_sel, ir_load, acc_load;
    logic alu_sub, pc_increment, pc_load, halted, phase_error, bus_error;

    logic [3:0] gen_phase;
    logic       ovr = 1'b0;
    logic [3:0] ovr_vec = 4'b0000;
    logic [3:0] phase_in;
    assign phase_in = ovr ? ovr_vec : gen_phase;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int ready_delay = 0;

    always #5 clock = ~clock;

    phase_controller #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .clear(clear),
        .fetch(phase_in[0]), .decode(phase_in[1]),
        .execute(phase_in[2]), .increment(phase_in[3]),
        .instruction(instruction), .mem_ready(mem_ready),
        .clock_enable(clock_enable), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .acc_load(acc_load),
        .alu_sub(alu_sub), .pc_increment(pc_increment), .pc_load(pc_load),
        .halted(halted), .phase_error(phase_error), .bus_error(bus_error)
    );

    // Sequence generator environment: one-hot ring advanced by clock_enable.
    always @(posedge clock) begin
        if (clear) gen_phase <= 4'b0001;
        else if (clock_enable) gen_phase <= {gen_phase[2:0], gen_phase[3]};
    end

    // Cycle index: 0 is the first cycle after the last clear edge.
    always @(posedge clock) begin
        if (clear) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Memory responder: raises mem_ready after ready_delay waiting cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clock);
            if (mem_read || mem_write) begin
                mem_ready = (wcnt >= ready_delay);
                wcnt++;
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard of expected events. stb = {ir, acc, sub, pinc, pload},
    // flg = {halted, phase_error, bus_error}.
    typedef struct packed {
        logic [31:0] cyc;
        logic        ce;
        logic [4:0]  stb;
        logic [2:0]  flg;
    } ev_t;

    ev_t sb[$];

    function automatic void push_ev(int c, logic ce, logic [4:0] stb, logic [2:0] flg);
        ev_t e;
        e.cyc = c; e.ce = ce; e.stb = stb; e.flg = flg;
        sb.push_back(e);
    endfunction

    // Monitor: an event is any clock_enable pulse or a rising sticky flag.
    initial begin
        logic ph, pp, pb;
        ev_t o, e;
        ph = 1'b0; pp = 1'b0; pb = 1'b0;
        forever begin
            @(negedge clock);
            if (clock_enable === 1'b1 || (halted === 1'b1 && !ph) ||
                (phase_error === 1'b1 && !pp) || (bus_error === 1'b1 && !pb)) begin
                o.cyc = cyc;
                o.ce  = clock_enable;
                o.stb = {ir_load, acc_load, alu_sub, pc_increment, pc_load};
                o.flg = {halted, phase_error, bus_error};
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got cyc=%0d ce=%b stb=%b flg=%b, required none",
                             o.cyc, o.ce, o.stb, o.flg);
                end else begin
                    e = sb.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d ce=%b stb=%b flg=%b, required cyc=%0d ce=%b stb=%b flg=%b",
                                 o.cyc, o.ce, o.stb, o.flg, e.cyc, e.ce, e.stb, e.flg);
                    end
                end
            end
            ph = (halted === 1'b1);
            pp = (phase_error === 1'b1);
            pb = (bus_error === 1'b1);
        end
    end

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic to_cycle(int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic chk_reset(string name);
        chk(name, {clock_enable, mem_read, mem_write, mem_addr_sel, ir_load, acc_load,
                   alu_sub, pc_increment, pc_load, halted, phase_error, bus_error}, 0);
    endtask

    task automatic chk_drain(string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ADD 0x3A: advance pulses at 2,4,6,8; mem_read only at cycle 1.
        instruction = 8'h3A;
        ready_delay = 0;
        do_clear();
        chk_reset("reset_state");
        push_ev(2, 1, 5'b10000, 3'b000);
        push_ev(4, 1, 5'b00000, 3'b000);
        push_ev(6, 1, 5'b01000, 3'b000);
        push_ev(8, 1, 5'b00010, 3'b000);
        for (int c = 0; c <= 9; c++) begin
            to_cycle(c);
            chk("add_mem_read", mem_read, (c == 1) ? 1 : 0);
        end
        chk_drain("add_drain");

        // SUB 0x47: acc_load with alu_sub at 6.
        instruction = 8'h47;
        do_clear();
        push_ev(2, 1, 5'b10000, 3'b000);
        push_ev(4, 1, 5'b00000, 3'b000);
        push_ev(6, 1, 5'b01100, 3'b000);
        push_ev(8, 1, 5'b00010, 3'b000);
        to_cycle(9);
        chk_drain("sub_drain");

        // JMP 0x57 then NOP 0x00: no PC+1 after the jump, PC+1 after the NOP.
        instruction = 8'h57;
        do_clear();
        push_ev(2, 1, 5'b10000, 3'b000);
        push_ev(4, 1, 5'b00000, 3'b000);
        push_ev(6, 1, 5'b00001, 3'b000);
        push_ev(8, 1, 5'b00000, 3'b000);
        push_ev(11, 1, 5'b10000, 3'b000);
        push_ev(13, 1, 5'b00000, 3'b000);
        push_ev(15, 1, 5'b00000, 3'b000);
        push_ev(17, 1, 5'b00010, 3'b000);
        to_cycle(10);
        instruction = 8'h00;
        to_cycle(18);
        chk_drain("jmp_nop_drain");

        // LDA 0x1C with mem_ready 4 cycles late in execute.
        instruction = 8'h1C;
        ready_delay = 0;
        do_clear();
        push_ev(2, 1, 5'b10000, 3'b000);
        push_ev(4, 1, 5'b00000, 3'b000);
        push_ev(11, 1, 5'b01000, 3'b000);
        push_ev(13, 1, 5'b00010, 3'b000);
        to_cycle(1);
        chk("lda_fetch_req", {mem_read, mem_addr_sel}, 2'b10);
        to_cycle(4);
        ready_delay = 4;
        for (int c = 5; c <= 11; c++) begin
            to_cycle(c);
            chk("lda_exec_req", {mem_read, mem_addr_sel}, (c >= 6 && c <= 10) ? 2'b11 : 2'b00);
        end
        to_cycle(14);
        chk_drain("lda_drain");

        // Timeout in fetch: 15 waiting cycles, then bus_error, no advance.
        ready_delay = 255;
        instruction = 8'h3A;
        do_clear();
        push_ev(16, 0, 5'b00000, 3'b001);
        to_cycle(15);
        chk("timeout_c15", {mem_read, bus_error}, 2'b10);
        to_cycle(16);
        chk("timeout_c16", {mem_read, bus_error, clock_enable}, 3'b010);
        to_cycle(25);
        chk("timeout_sticky", bus_error, 1);
        chk_drain("timeout_drain");
        ready_delay = 0;
        do_clear();
        chk_reset("timeout_clear");
        push_ev(2, 1, 5'b10000, 3'b000);
        to_cycle(1);
        chk("refetch_mem_read", mem_read, 1);
        to_cycle(3);
        chk_drain("refetch_drain");

        // Illegal phase vector at DISPATCH.
        do_clear();
        ovr_vec = 4'b0011;
        ovr = 1'b1;
        push_ev(1, 0, 5'b00000, 3'b010);
        to_cycle(1);
        chk("perr_dispatch", {mem_read, phase_error}, 2'b01);
        to_cycle(5);
        chk("perr_sticky", {phase_error, clock_enable}, 2'b10);
        chk_drain("perr_dispatch_drain");
        ovr = 1'b0;

        // Phase changes while waiting on memory.
        ready_delay = 255;
        do_clear();
        push_ev(3, 0, 5'b00000, 3'b010);
        to_cycle(2);
        chk("perr_wait_req", mem_read, 1);
        ovr_vec = 4'b0010;
        ovr = 1'b1;
        to_cycle(3);
        chk("perr_wait", {mem_read, phase_error, bus_error}, 3'b010);
        to_cycle(5);
        chk_drain("perr_wait_drain");
        ovr = 1'b0;
        ready_delay = 0;

        // HLT 0xF0: halted at 6, no further advance for 50 cycles.
        instruction = 8'hF0;
        do_clear();
        push_ev(2, 1, 5'b10000, 3'b000);
        push_ev(4, 1, 5'b00000, 3'b000);
        push_ev(6, 0, 5'b00000, 3'b100);
        to_cycle(56);
        chk("halt_hold", {halted, clock_enable}, 2'b10);
        chk_drain("halt_drain");

        // STA 0x25: clear during the write handshake drops mem_write.
        instruction = 8'h25;
        ready_delay = 0;
        do_clear();
        chk_reset("halt_clear");
        push_ev(2, 1, 5'b10000, 3'b000);
        push_ev(4, 1, 5'b00000, 3'b000);
        to_cycle(4);
        ready_delay = 255;
        to_cycle(7);
        chk("sta_req", {mem_write, mem_read, mem_addr_sel}, 3'b101);
        to_cycle(8);
        clear = 1'b1;
        @(negedge clock);
        chk("sta_clear_drop", {mem_write, mem_addr_sel}, 2'b00);
        clear = 1'b0;
        chk_drain("sta_drain");
        ready_delay = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
